system: RTL and testbench
=========================

Name: system

Overview:
- Minimal board-level top for the SoC bring-up: UART echo console with LED status and button-triggered characters.
- Contains an 8N1 UART receiver and transmitter, a TX arbiter, and button synchronisers.
- Received bytes are echoed on uart_tx and latched onto led.
- A rising edge on btn[n] transmits ASCII '0'+n.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- DIVISOR (localparam) = CLK_FREQ/BAUD, integer truncation; 868 with the defaults. It is clocks per bit and must be >= 4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- btn  in  4  push buttons, asynchronous, active-high
- uart_rx  in  1  serial input, idle high, asynchronous
- uart_tx  out  1  serial output, idle high
- led  out  8  last correctly received byte

Behaviour:
- Reset: every flop clears asynchronously.
  - led=0x00, uart_tx=1, RX and TX FSMs in IDLE, pending flags 0.
  - Synchroniser flops reset to their idle levels: rx=1, btn=0.
- Synchronisers:
  - uart_rx and each btn bit pass through a 2-FF synchroniser.
  - A button event is a rising edge of the synchronised bit, giving a 1-cycle pulse. There is no debounce.
- RX FSM, states IDLE -> START -> DATA -> STOP:
  - IDLE: wait for the synchronised rx to be 0. Load the counter with DIVISOR/2 and enter START.
  - START: at counter expiry sample rx. If 1 it is a false start: return to IDLE. If 0 enter DATA with the counter at DIVISOR.
  - DATA: 8 samples, one every DIVISOR cycles, shifted in LSB first.
  - STOP: sample after DIVISOR cycles.
    - If 1: pulse rx_valid for 1 cycle with the byte.
    - If 0 (framing error): discard the byte and leave led unchanged.
    - Either way, return to IDLE. IDLE re-arms only after seeing rx=1 (break protection).
- led: loads the byte on the clock edge after rx_valid and holds it until the next valid byte.
- TX FSM, states IDLE -> START -> DATA -> STOP:
  - Each bit lasts exactly DIVISOR cycles: start 0, 8 data bits LSB first, stop 1.
  - A frame is 10*DIVISOR cycles.
  - uart_tx is driven from a register, so it is glitch-free.
- Arbiter:
  - One-entry echo register plus a 4-bit button pending mask.
  - rx_valid sets the echo flag and byte. A new byte overwrites an unsent one.
  - A button pulse sets its mask bit. Repeat pulses while that bit is pending are merged.
  - When TX is IDLE and anything is pending:
    - The echo flag has priority.
    - Otherwise the lowest-index pending button is sent, as byte 0x30+index.
    - The grant clears the flag or mask bit in the same cycle the TX loads.
  - TX may start a new frame the cycle after its stop bit completes, giving back-to-back frames.
- Latency:
  - uart_tx falls exactly 2 cycles after the rx_valid pulse when TX is idle: the echo flag is set in the first cycle, load/start in the second.
  - For a button, uart_tx falls 4 cycles after the btn rising edge when TX is idle: 2 sync cycles, 1 edge-detect cycle, 1 grant cycle.
- Simultaneous events:
  - Echo and button in the same cycle: both are recorded and the echo is sent first.
  - Multiple buttons rising together: all are recorded and sent in ascending index order.
- Reset mid-frame: uart_tx returns to 1 immediately and all pending work is lost.

Decomposition:
- Package soc_pkg holds:
  - the DIVISOR computation function;
  - ASCII_ZERO = 8'h30;
  - RX/TX state enums.
- Sub-module uart_core (clk, rst, rx, tx, rx_data, rx_valid, tx_data, tx_start, tx_busy) contains both FSMs.
- system holds the synchronisers, the arbiter and the led register.

Test Plan:
- All tests use CLK_FREQ=1000000, BAUD=100000, giving DIVISOR=10.
- Reset: assert rst mid-run -> uart_tx=1 and led=0x00 immediately. Nothing is transmitted after release with idle inputs.
- Echo: send 0xA5 8N1 on uart_rx -> led=0xA5. uart_tx carries the frame 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 10 cycles, starting 2 cycles after rx_valid.
- Framing error: send 0x3C with stop bit 0, then release the line -> led stays at its old value and no TX frame occurs. The next valid byte 0x11 is received correctly.
- False start: 3-cycle low glitch on uart_rx -> no rx_valid and no TX activity.
- Buttons: btn=4'b0101 rising together -> TX frames 0x30 then 0x32, back-to-back with 20*DIVISOR total duration. Holding btn high produces no further frames.
- Priority: a byte 0x55 completes while button 1's frame is transmitting and button 3 is pending -> after the current frame, 0x55 is sent, then 0x33.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared definitions for the bring-up console: baud divisor helper,
// ASCII base for button characters and the UART FSM state encodings.
package soc_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Clocks per UART bit, integer truncation; the result must be >= 4.
    function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/system_if.sv
// Board pin bundle of the console: buttons, serial lines and LEDs.
// master = the driving side (board or bench), slave = the console logic.
interface system_if;
    logic [3:0] btn;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] led;

    modport master (output btn, output uart_rx, input uart_tx, input led);
    modport slave  (input btn, input uart_rx, output uart_tx, output led);
endinterface

// File: rtl/uart_core.sv
// 8N1 UART receiver and transmitter sharing one bit divisor.
// rx is expected to be synchronised already; tx is a registered output.
module uart_core
    import soc_pkg::*;
#(
    parameter int unsigned DIVISOR = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy
);

    localparam int unsigned CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rx_state_e        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [7:0]       rx_sh, rx_sh_n;
    logic             rx_armed, rx_armed_n;
    logic             rx_valid_n;

    tx_state_e        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [7:0]       tx_sh, tx_sh_n;
    logic             tx_n;

    assign rx_data = rx_sh;

    // State and datapath registers of both FSMs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_armed <= 1'b0;
            rx_valid <= 1'b0;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx       <= 1'b1;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            rx_armed <= rx_armed_n;
            rx_valid <= rx_valid_n;
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            tx       <= tx_n;
        end
    end

    // Receiver next state: half-bit start check, then sample every DIVISOR.
    // After any frame IDLE waits for the line to go high before re-arming,
    // so a held-low line (break) cannot retrigger reception.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_armed_n = rx_armed;
        rx_valid_n = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (!rx_armed) begin
                    if (rx) rx_armed_n = 1'b1;
                end else if (!rx) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = CNT_HALF;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (rx) begin
                        rx_state_n = RX_IDLE;
                        rx_armed_n = 1'b0;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = CNT_BIT;
                        rx_idx_n   = '0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_sh_n  = {rx, rx_sh[7:1]};
                    rx_cnt_n = CNT_BIT;
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                    else                rx_idx_n   = rx_idx + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_valid_n = rx;
                    rx_state_n = RX_IDLE;
                    rx_armed_n = 1'b0;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Transmitter next state: each bit held exactly DIVISOR cycles. A start
    // request in the last stop-bit cycle chains the next frame with no gap.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_sh_n    = tx_sh;
        tx_n       = tx;
        unique case (tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = CNT_BIT;
                    tx_sh_n    = tx_data;
                    tx_n       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = CNT_BIT;
                    tx_idx_n   = '0;
                    tx_n       = tx_sh[0];
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = CNT_BIT;
                    if (tx_idx == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_n       = 1'b1;
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                        tx_sh_n  = {1'b0, tx_sh[7:1]};
                        tx_n     = tx_sh[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    if (tx_start) begin
                        tx_state_n = TX_START;
                        tx_cnt_n   = CNT_BIT;
                        tx_sh_n    = tx_data;
                        tx_n       = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // Busy drops during the final stop-bit cycle so a new frame can follow.
    always_comb begin
        tx_busy = !((tx_state == TX_IDLE) ||
                    ((tx_state == TX_STOP) && (tx_cnt == '0)));
    end

endmodule

// File: rtl/system.sv
// Bring-up console top: input synchronisers, echo/button TX arbiter,
// LED latch of the last good byte, and the UART core.
module system
    import soc_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] led
);

    // Clocks per bit; must be at least 4 for the half-bit start check.
    localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD);

    logic [1:0] rx_sync;
    logic [3:0] btn_s1, btn_s2, btn_prev;
    logic [3:0] btn_rise;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    logic       echo_pend;
    logic [7:0] echo_byte;
    logic [3:0] btn_pend;

    logic       grant_echo;
    logic [3:0] grant_btn;
    logic [1:0] btn_idx;
    logic       btn_found;

    // Two-flop synchronisers reset to idle levels; previous-button register for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx};
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_rise = btn_s2 & ~btn_prev;

    // Pending work: one echo slot (newest byte wins) and a merged button mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_pend <= 1'b0;
            echo_byte <= '0;
            btn_pend  <= '0;
            led       <= '0;
        end else begin
            if (rx_valid) begin
                echo_pend <= 1'b1;
                echo_byte <= rx_data;
                led       <= rx_data;
            end else if (grant_echo) begin
                echo_pend <= 1'b0;
            end
            btn_pend <= (btn_pend & ~grant_btn) | btn_rise;
        end
    end

    // Grant when TX can accept: echo first, else lowest pending button.
    always_comb begin
        btn_idx   = '0;
        btn_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (btn_pend[i] && !btn_found) begin
                btn_found = 1'b1;
                btn_idx   = 2'(i);
            end
        end
        tx_start   = !tx_busy && (echo_pend || btn_found);
        grant_echo = tx_start && echo_pend;
        grant_btn  = (tx_start && !echo_pend) ? (4'b0001 << btn_idx) : '0;
        tx_data    = echo_pend ? echo_byte : (ASCII_ZERO + {6'b0, btn_idx});
    end

    uart_core #(
        .DIVISOR(DIVISOR)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx_sync[1]),
        .tx      (uart_tx),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .tx_busy (tx_busy)
    );

endmodule

// File: tb/tb_system.sv
// Directed bench for the bring-up console at DIVISOR = 10.
module tb_system;

    localparam int D = 10;

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       sbit;
        logic       stop;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   falls = 0;
    logic tx_q = 1'b1;
    frame_t frames[$];

    system_if bus ();

    system #(
        .CLK_FREQ(1000000),
        .BAUD    (100000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (bus.btn),
        .uart_rx(bus.uart_rx),
        .uart_tx(bus.uart_tx),
        .led    (bus.led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count every falling edge of uart_tx.
    always @(negedge clk) begin
        if (tx_q && !bus.uart_tx) falls <= falls + 1;
        tx_q <= bus.uart_tx;
    end

    // Decode uart_tx frames, sampling mid-bit, and record their start cycle.
    initial begin
        logic   prev;
        frame_t f;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !bus.uart_tx) begin
                f.start = cyc;
                repeat (D / 2) @(negedge clk);
                f.sbit = bus.uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    f.data[i] = bus.uart_tx;
                end
                repeat (D) @(negedge clk);
                f.stop = bus.uart_tx;
                frames.push_back(f);
                prev = bus.uart_tx;
            end else begin
                prev = bus.uart_tx;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, frames.size(), n);
    endtask

    // Drive one 8N1 frame starting at the current negedge; s = its start cycle.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, output int s);
        s = cyc;
        bus.uart_rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (D) @(negedge clk);
        end
        bus.uart_rx = stop_bit;
        repeat (D) @(negedge clk);
        bus.uart_rx = 1'b1;
    endtask

    initial begin
        int s;
        int n0;
        int f0;
        logic [9:0] fb;

        bus.btn = 4'b0000;
        bus.uart_rx = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", bus.uart_tx, 1'b1);
        check("reset_led", bus.led, 8'h00);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_no_frames", frames.size(), 0);

        // Echo of 0xA5: tx falls 100 cycles after the rx start bit begins
        send_rx(8'hA5, 1'b1, s);
        wait_frames(1, 200, "echo_frame_seen");
        if (frames.size() >= 1) begin
            check("echo_data", frames[0].data, 8'hA5);
            check("echo_framing", {frames[0].sbit, frames[0].stop}, 2'b01);
            check("echo_start", frames[0].start, s + 10 * D);
        end
        check("echo_led", bus.led, 8'hA5);

        // Framing error leaves led and TX alone
        n0 = frames.size();
        send_rx(8'h3C, 1'b0, s);
        repeat (200) @(negedge clk);
        check("ferr_no_frame", frames.size(), n0);
        check("ferr_led", bus.led, 8'hA5);
        send_rx(8'h11, 1'b1, s);
        wait_frames(n0 + 1, 200, "after_ferr_frame_seen");
        if (frames.size() >= n0 + 1) begin
            check("after_ferr_data", frames[n0].data, 8'h11);
            check("after_ferr_start", frames[n0].start, s + 10 * D);
        end
        check("after_ferr_led", bus.led, 8'h11);

        // False start glitch
        n0 = frames.size();
        bus.uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_frame", frames.size(), n0);
        check("glitch_led", bus.led, 8'h11);

        // Buttons 0 and 2 together: '0' then '2' back to back
        n0 = frames.size();
        s = cyc;
        bus.btn = 4'b0101;
        wait_frames(n0 + 2, 400, "btn_frames_seen");
        if (frames.size() >= n0 + 2) begin
            check("btn0_data", frames[n0].data, 8'h30);
            check("btn0_start", frames[n0].start, s + 4);
            check("btn2_data", frames[n0 + 1].data, 8'h32);
            check("btn2_start", frames[n0 + 1].start, s + 4 + 10 * D);
            check("btn2_stop", frames[n0 + 1].stop, 1'b1);
        end
        repeat (300) @(negedge clk);
        check("btn_hold_no_repeat", frames.size(), n0 + 2);
        bus.btn = 4'b0000;
        repeat (20) @(negedge clk);

        // Priority: 0x55 completes during btn1's frame with btn3 pending
        n0 = frames.size();
        fb = {1'b1, 8'h55, 1'b0};
        s = cyc;
        for (int c = 0; c < 110; c++) begin
            bus.uart_rx = (c < 100) ? fb[c / 10] : 1'b1;
            if (c == 5) bus.btn[1] = 1'b1;
            if (c == 20) bus.btn[3] = 1'b1;
            @(negedge clk);
        end
        wait_frames(n0 + 3, 400, "prio_frames_seen");
        if (frames.size() >= n0 + 3) begin
            check("prio_first_data", frames[n0].data, 8'h31);
            check("prio_first_start", frames[n0].start, s + 9);
            check("prio_echo_data", frames[n0 + 1].data, 8'h55);
            check("prio_echo_start", frames[n0 + 1].start, s + 9 + 10 * D);
            check("prio_btn3_data", frames[n0 + 2].data, 8'h33);
            check("prio_btn3_start", frames[n0 + 2].start, s + 9 + 20 * D);
        end
        check("prio_led", bus.led, 8'h55);
        bus.btn = 4'b0000;
        repeat (20) @(negedge clk);

        // Reset in the middle of a frame
        bus.btn[2] = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_reset_tx_low", bus.uart_tx, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_tx", bus.uart_tx, 1'b1);
        check("midrst_led", bus.led, 8'h00);
        bus.btn = 4'b0000;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        f0 = falls;
        repeat (300) @(negedge clk);
        check("post_reset_silent", falls, f0);
        check("post_reset_led", bus.led, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
